time_set_controller: RTL and testbench
======================================

# time_set_controller

Sequences the hour/minute/second counters of the clock datapath. It conditions two raw push-buttons and runs a RUN / SET_HOUR / SET_MINUTE state machine. From that it drives:
- the carry-enable for the minute and hour counters,
- single-cycle increment and clear strobes,
- per-field blink masks for the segment display driver.

It sits between the board inputs and the counter/display logic in the top level.

## Interface
- DEBOUNCE_CYCLES, 1024: consecutive stable cycles needed before a debounced level changes.
- REPEAT_DELAY, 32768: cycles an inc button is held after its first press pulse before auto-repeat starts.
- REPEAT_PERIOD, 8192: cycles between auto-repeat pulses.
- BLINK_BITS, 15: width of the blink phase counter; its MSB is the blank phase.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_mode  in  1  raw mode button, asynchronous, active high
- btn_inc  in  1  raw increment button, asynchronous, active high
- tick_in  in  1  one-cycle pulse per second from the second counter
- run_enable  out  1  high only in RUN; gates minute/hour carries
- clear_seconds  out  1  one-cycle strobe; seconds counter loads 0
- hour_inc  out  1  one-cycle strobe; hour counter +1 (wraps 23→0 in datapath)
- minute_inc  out  1  one-cycle strobe; minute counter +1 (wraps 59→0 in datapath), no carry to hour
- blink_mask  out  2  [1] blank hour field, [0] blank minute field
- mode  out  2  current state encoding

## Operation
- Reset values: state RUN, run_enable=1, mode=0, all other outputs 0. All counters are 0 and debounced levels are 0.
- Button conditioning:
  - Each button passes through a 2-flop synchronizer.
  - Debounced level follows the synchronized level after DEBOUNCE_CYCLES consecutive cycles of disagreement. Any agreeing cycle restarts the count.
  - A press pulse is the rising edge of the debounced level.
- Auto-repeat (inc button only): while the debounced level stays high, one extra press pulse is emitted REPEAT_DELAY cycles after the first pulse, then one every REPEAT_PERIOD cycles. Release stops repeat immediately.
- FSM states: RUN=0, SET_HOUR=1, SET_MINUTE=2. Encoding 3 is unreachable and recovers to RUN next cycle.
- Transitions:
  - mode press: RUN→SET_HOUR→SET_MINUTE→RUN.
  - Timeout: 30 tick_in pulses in a SET state with no press of either button → RUN. Each press resets the timeout counter.
- inc press: in SET_HOUR asserts hour_inc; in SET_MINUTE asserts minute_inc; in RUN it is ignored.
- clear_seconds fires on every SET_MINUTE→RUN and timeout→RUN transition. It does not fire on RUN→SET_HOUR.
- Blink:
  - The phase counter free-runs and is cleared on every state entry, so the field shows immediately.
  - blink_mask[1] = (state==SET_HOUR) & MSB; blink_mask[0] = (state==SET_MINUTE) & MSB.

## Timing
- A raw edge held stable gives its press pulse exactly DEBOUNCE_CYCLES+3 rising edges later.
- State, mode, run_enable and the strobes are all registered. They update on the edge after the press pulse.
- Strobes are exactly 1 cycle wide. hour_inc and minute_inc are never high together.
- mode and inc presses in the same cycle: mode wins, the inc press is dropped, and no strobe is issued.
- tick_in in the same cycle as a press: the press wins and the timeout counter clears.
- run_enable falls on the cycle SET_HOUR is entered and rises on the cycle RUN is re-entered, together with clear_seconds.
- Reset asserted mid-set: immediate return to RUN. A strobe in flight is cancelled. Any auto-repeat is cancelled; it needs a fresh press after release.
- Releasing inc before the first repeat gives exactly one increment.

## Structure
- Package clock_ctrl_pkg holds:
  - state encodings RUN/SET_HOUR/SET_MINUTE,
  - TIMEOUT_SECONDS=30,
  - timeout counter width (5 bits).
- Sub-module button_conditioner contains synchronizer, debounce counter, edge detect and optional auto-repeat.
  - Parameter REPEAT_EN: 0 for mode, 1 for inc.
  - Instantiated twice.
- The top of this block holds the FSM, timeout counter, blink counter and output registers.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, BLINK_BITS=3.
- Reset, then idle 50 cycles → run_enable=1, mode=0, blink_mask=0, no strobes.
- Glitchy mode: 3-cycle pulse, then a clean 10-cycle press → no transition for the glitch; mode=1 and run_enable=0 at edge 4+3+1 after the clean press.
- SET_HOUR, inc held 40 cycles → hour_inc pulses at press time, +20, +25, +30, +35: 5 total. Release → no further pulses.
- Full cycle: mode, inc, mode, inc×2, mode → 1 hour_inc, 2 minute_inc. Then mode=0, run_enable=1, and clear_seconds is high for 1 cycle on the same edge.
- Timeout: enter SET_MINUTE, drive 30 tick_in pulses with no press → RUN plus clear_seconds on the cycle after the 30th tick. 29 ticks then an inc press, then 29 ticks → still SET_MINUTE.
- Same-cycle mode+inc press in SET_HOUR → mode=2, no hour_inc. Reset asserted while inc held → immediate RUN, no repeat pulses after reset release until a fresh press.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding and timeout constants for the time-set controller.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      SET_HOUR   = 2'd1,
      SET_MINUTE = 2'd2
   } state_e;

   localparam int unsigned TIMEOUT_SECONDS = 30;
   localparam int unsigned TIMEOUT_W       = 5;

   typedef logic [TIMEOUT_W-1:0] timeout_t;

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects one push-button, with optional auto-repeat.
module button_conditioner
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1024,
   parameter int unsigned REPEAT_DELAY    = 32768,
   parameter int unsigned REPEAT_PERIOD   = 8192,
   parameter bit          REPEAT_EN       = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
   localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD);
   localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);

   logic             sync1_q, sync2_q;
   logic [1:0]       settle_q;
   logic             level_q, level_d, level_dly_q;
   logic             lock_q, lock_d;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_armed_q, rep_armed_d;
   logic             press_q, press_d;
   logic             rise, rep_fire;

   always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync2_q != level_q) begin
         if (db_cnt_q == DB_LAST) level_d = sync2_q;
         else                     db_cnt_d = db_cnt_q + DB_ONE;
      end

      // After reset the button must be seen released before any press is honoured.
      lock_d = lock_q;
      if (settle_q[1] && !sync2_q && !level_q) lock_d = 1'b0;

      rise        = level_q & ~level_dly_q & ~lock_q;
      rep_fire    = 1'b0;
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
      if (REPEAT_EN && level_q && !lock_q) begin
         rep_armed_d = rep_armed_q;
         if (rise) begin
            rep_cnt_d   = REP_ONE;
            rep_armed_d = 1'b0;
         end else if (rep_cnt_q == (rep_armed_q ? REP_PERIOD : REP_DELAY)) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = REP_ONE;
            rep_armed_d = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + REP_ONE;
         end
      end

      press_d = rise | rep_fire;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         settle_q    <= 2'b00;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         lock_q      <= 1'b1;
         db_cnt_q    <= '0;
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= btn;
         sync2_q     <= sync1_q;
         settle_q    <= {settle_q[0], 1'b1};
         level_q     <= level_d;
         level_dly_q <= level_q;
         lock_q      <= lock_d;
         db_cnt_q    <= db_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_armed_q <= rep_armed_d;
         press_q     <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/time_set_controller.sv
// RUN / SET_HOUR / SET_MINUTE sequencer for the clock datapath: strobes, carry gate, blink.
module time_set_controller
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1024,
   parameter int unsigned REPEAT_DELAY    = 32768,
   parameter int unsigned REPEAT_PERIOD   = 8192,
   parameter int unsigned BLINK_BITS      = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       tick_in,
   output logic       run_enable,
   output logic       clear_seconds,
   output logic       hour_inc,
   output logic       minute_inc,
   output logic [1:0] blink_mask,
   output logic [1:0] mode
);

   localparam timeout_t                TIMEOUT_LAST = timeout_t'(TIMEOUT_SECONDS - 1);
   localparam timeout_t                TIMEOUT_ONE  = timeout_t'(1);
   localparam logic [BLINK_BITS-1:0]   BLINK_ONE    = BLINK_BITS'(1);

   logic mode_press, inc_press;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (1'b0)
   ) u_mode_btn (
      .clock (clock),
      .reset (reset),
      .btn   (btn_mode),
      .press (mode_press)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (1'b1)
   ) u_inc_btn (
      .clock (clock),
      .reset (reset),
      .btn   (btn_inc),
      .press (inc_press)
   );

   state_e                state_q, state_d;
   timeout_t              tcnt_q, tcnt_d;
   logic [BLINK_BITS-1:0] blink_q, blink_d;
   logic                  run_en_q, run_en_d;
   logic                  clear_q, clear_d;
   logic                  hour_q, hour_d;
   logic                  minute_q, minute_d;

   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      hour_d   = 1'b0;
      minute_d = 1'b0;
      case (state_q)
         RUN: begin
            tcnt_d = '0;
            if (mode_press) state_d = SET_HOUR;
         end
         SET_HOUR, SET_MINUTE: begin
            // Mode outranks inc, and any press outranks a coincident tick.
            if (mode_press) begin
               state_d = (state_q == SET_HOUR) ? SET_MINUTE : RUN;
            end else if (inc_press) begin
               hour_d   = (state_q == SET_HOUR);
               minute_d = (state_q == SET_MINUTE);
               tcnt_d   = '0;
            end else if (tick_in) begin
               if (tcnt_q == TIMEOUT_LAST) state_d = RUN;
               else                        tcnt_d  = tcnt_q + TIMEOUT_ONE;
            end
         end
         default: state_d = RUN;
      endcase

      clear_d  = (state_d == RUN) && ((state_q == SET_HOUR) || (state_q == SET_MINUTE));
      run_en_d = (state_d == RUN);
      blink_d  = blink_q + BLINK_ONE;
      if (state_d != state_q) begin
         blink_d = '0;
         tcnt_d  = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= RUN;
         tcnt_q   <= '0;
         blink_q  <= '0;
         run_en_q <= 1'b1;
         clear_q  <= 1'b0;
         hour_q   <= 1'b0;
         minute_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         blink_q  <= blink_d;
         run_en_q <= run_en_d;
         clear_q  <= clear_d;
         hour_q   <= hour_d;
         minute_q <= minute_d;
      end
   end

   assign run_enable    = run_en_q;
   assign clear_seconds = clear_q;
   assign hour_inc      = hour_q;
   assign minute_inc    = minute_q;
   assign mode          = state_q;
   assign blink_mask    = {(state_q == SET_HOUR)   & blink_q[BLINK_BITS-1],
                           (state_q == SET_MINUTE) & blink_q[BLINK_BITS-1]};

endmodule

// File: tb/tb_time_set_controller.sv
// Directed plus random stimulus for time_set_controller against a behavioural model.
module tb_time_set_controller;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 5;
   localparam int BB = 3;

   logic       clock = 1'b0;
   logic       reset, btn_mode, btn_inc, tick_in;
   logic       run_enable, clear_seconds, hour_inc, minute_inc;
   logic [1:0] blink_mask, mode;

   always #5 clock = ~clock;

   time_set_controller #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .BLINK_BITS      (BB)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .btn_mode      (btn_mode),
      .btn_inc       (btn_inc),
      .tick_in       (tick_in),
      .run_enable    (run_enable),
      .clear_seconds (clear_seconds),
      .hour_inc      (hour_inc),
      .minute_inc    (minute_inc),
      .blink_mask    (blink_mask),
      .mode          (mode)
   );

   int checks = 0;
   int failures = 0;
   int cnt_hour = 0, cnt_min = 0, cnt_clear = 0;

   // Model: button i (0 = mode, 1 = inc)
   int          n;
   bit          b_p1[2], b_p2[2], b_level[2], b_lock[2], b_pulse[2];
   int          b_rise[2], b_since[2];
   logic [15:0] b_hist[2];
   // Model: sequencer
   int          m_state, m_tcnt, m_phase;
   bit          m_clear, m_hour, m_min;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n = 0;
      for (int b = 0; b < 2; b++) begin
         b_p1[b] = 0; b_p2[b] = 0; b_level[b] = 0; b_lock[b] = 1; b_pulse[b] = 0;
         b_rise[b] = -1; b_since[b] = 0; b_hist[b] = '0;
      end
      m_state = 0; m_tcnt = 0; m_phase = 0; m_clear = 0; m_hour = 0; m_min = 0;
   endtask

   task automatic model_step();
      int  prev, k;
      bit  raw, s;
      logic [15:0] mask;
      n++;
      prev = m_state;
      m_clear = 0; m_hour = 0; m_min = 0;
      if (m_state == 0) begin
         if (b_pulse[0]) m_state = 1;
      end else if (b_pulse[0]) begin
         m_state = (m_state == 1) ? 2 : 0;
      end else if (b_pulse[1]) begin
         m_hour = (m_state == 1); m_min = (m_state == 2); m_tcnt = 0;
      end else if (tick_in) begin
         m_tcnt++;
         if (m_tcnt == 30) m_state = 0;
      end
      if (m_state != prev) begin
         m_tcnt = 0; m_phase = 0; m_clear = (m_state == 0);
      end else begin
         m_phase = (m_phase + 1) % (1 << BB);
      end

      mask = 16'((1 << D) - 1);
      for (int b = 0; b < 2; b++) begin
         raw = (b == 1) ? btn_inc : btn_mode;
         s = b_p2[b]; b_p2[b] = b_p1[b]; b_p1[b] = raw;
         // Press one cycle after the debounced rise, repeats RD then every RP after it.
         k = n - 1 - b_rise[b];
         b_pulse[b] = (b_rise[b] >= 0) &&
                      ((n == b_rise[b] + 1) || (b == 1 && k >= RD && (k - RD) % RP == 0));
         if (b_lock[b] && n >= 3 && !s && !b_level[b]) b_lock[b] = 0;
         b_hist[b] = {b_hist[b][14:0], s};
         b_since[b]++;
         if (b_since[b] >= D && ((b_hist[b] & mask) == (b_level[b] ? 16'h0 : mask))) begin
            b_level[b] = !b_level[b];
            b_since[b] = 0;
            b_rise[b]  = (b_level[b] && !b_lock[b]) ? n : -1;
         end
      end
   endtask

   function automatic logic [7:0] model_vec();
      return {m_state == 0, m_clear, m_hour, m_min,
              m_state == 1 && m_phase >= (1 << (BB - 1)),
              m_state == 2 && m_phase >= (1 << (BB - 1)), 2'(m_state)};
   endfunction

   task automatic cyc();
      @(posedge clock);
      if (!reset) model_step();
      @(negedge clock);
      check("outputs", {run_enable, clear_seconds, hour_inc, minute_inc, blink_mask, mode},
            model_vec());
      cnt_hour  += int'(hour_inc);
      cnt_min   += int'(minute_inc);
      cnt_clear += int'(clear_seconds);
   endtask

   task automatic press(input bit m, input bit i, input int len, input int gap);
      btn_mode = m; btn_inc = i;
      repeat (len) cyc();
      btn_mode = 0; btn_inc = 0;
      repeat (gap) cyc();
   endtask

   task automatic ticks(input int num);
      for (int t = 0; t < num; t++) begin
         tick_in = 1; cyc(); tick_in = 0;
         repeat ($urandom_range(0, 2)) cyc();
      end
   endtask

   initial begin
      int first, h0, m0, c0, hold_m, hold_i;
      btn_mode = 0; btn_inc = 0; tick_in = 0; reset = 0;
      model_reset();
      #1 reset = 1;
      repeat (2) @(negedge clock);
      check("reset_state", {run_enable, clear_seconds, hour_inc, minute_inc, blink_mask, mode},
            8'b1000_0000);
      reset = 0;

      // Idle with random ticks: ticks in RUN do nothing.
      for (int i = 0; i < 50; i++) begin
         tick_in = ($urandom_range(0, 3) == 0); cyc();
      end
      tick_in = 0;
      check("idle_strobes", cnt_hour + cnt_min + cnt_clear, 0);

      // Glitch shorter than the debounce window.
      press(1, 0, 3, 10);
      check("glitch_ignored", mode, 2'd0);

      // Clean mode press latency.
      btn_mode = 1; first = 0;
      for (int e = 1; e <= 10; e++) begin
         cyc();
         if (first == 0 && mode == 2'd1) first = e;
      end
      btn_mode = 0;
      repeat (10) cyc();
      check("mode_latency", first, D + 4);
      check("set_hour_run_en", run_enable, 1'b0);

      // Held inc in SET_HOUR: first press plus four repeats.
      h0 = cnt_hour;
      press(0, 1, 40, 20);
      check("repeat_count", cnt_hour - h0, 5);

      press(1, 0, 8, 8);
      press(1, 0, 8, 8);
      check("back_to_run", mode, 2'd0);

      // Full cycle.
      h0 = cnt_hour; m0 = cnt_min; c0 = cnt_clear;
      press(1, 0, 8, 8);
      press(0, 1, 8, 8);
      press(1, 0, 8, 8);
      press(0, 1, 8, 8);
      press(0, 1, 8, 8);
      press(1, 0, 8, 8);
      check("cycle_hour", cnt_hour - h0, 1);
      check("cycle_minute", cnt_min - m0, 2);
      check("cycle_clear", cnt_clear - c0, 1);
      check("cycle_end", {run_enable, mode}, 3'b100);

      // Timeout after 30 ticks in SET_MINUTE.
      press(1, 0, 8, 8);
      press(1, 0, 8, 8);
      ticks(29);
      check("pre_timeout", mode, 2'd2);
      tick_in = 1; cyc(); tick_in = 0;
      check("timeout_run", {mode, clear_seconds, run_enable}, 4'b0011);

      // An inc press restarts the timeout.
      press(1, 0, 8, 8);
      press(1, 0, 8, 8);
      ticks(29);
      press(0, 1, 8, 8);
      ticks(29);
      check("timeout_restart", mode, 2'd2);

      // Coincident mode+inc in SET_HOUR: mode wins.
      press(1, 0, 8, 8);
      press(1, 0, 8, 8);
      check("in_set_hour", mode, 2'd1);
      h0 = cnt_hour;
      press(1, 1, 8, 8);
      check("mode_wins", mode, 2'd2);
      check("inc_dropped", cnt_hour - h0, 0);

      // Reset while inc is held and repeating.
      btn_inc = 1;
      repeat (30) cyc();
      reset = 1; model_reset();
      #1;
      check("reset_mid", {run_enable, clear_seconds, hour_inc, minute_inc, blink_mask, mode},
            8'b1000_0000);
      repeat (2) cyc();
      reset = 0;
      h0 = cnt_hour; m0 = cnt_min;
      repeat (40) cyc();
      check("no_repeat_after_reset", (cnt_hour - h0) + (cnt_min - m0), 0);
      btn_inc = 0;
      repeat (12) cyc();
      press(1, 0, 8, 8);
      h0 = cnt_hour;
      press(0, 1, 8, 8);
      check("fresh_press", cnt_hour - h0, 1);

      // Random buttons and ticks.
      hold_m = 0; hold_i = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold_m == 0) begin btn_mode = 1'($urandom); hold_m = $urandom_range(1, 30); end
         if (hold_i == 0) begin btn_inc = 1'($urandom); hold_i = $urandom_range(1, 45); end
         tick_in = ($urandom_range(0, 4) == 0);
         cyc();
         hold_m--; hold_i--;
      end
      btn_mode = 0; btn_inc = 0; tick_in = 0;
      repeat (10) cyc();
      check("strobes_exclusive", hour_inc & minute_inc, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
